lsu_split: RTL and testbench
============================

Name: lsu_split

Overview:
- Parametrised load/store unit; successor to the single-cycle core's direct data-memory hookup.
- Sits between the core's execute stage and a handshaked word-organised data memory.
- Handles byte/half/word loads and stores with sign/zero extension and byte strobes.
- Adds multi-cycle memory latency and optional misaligned-access splitting into two word transactions.

Parameters:
- ADDR_WIDTH, 32, byte-address width of request and memory ports.
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two transactions; 0 = flag them as errors.
- DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 encoding of the access.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal funct3 or disallowed misalignment.
- mem_req  out  1  memory transaction request, held until ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_wstrb  out  4  byte write strobes.
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  memory completes the current transaction in this cycle.
- mem_rdata  in  32  read word, valid when mem_ack is high.

Behaviour:
- Reset:
  - State = IDLE.
  - req_ready = 1.
  - resp_valid, resp_err, mem_req, mem_we = 0.
  - mem_addr, mem_wstrb, mem_wdata, resp_rdata = 0.
  - Reset mid-transaction: mem_req drops immediately; the pending access is abandoned and no response is issued.
- All outputs are registered except req_ready, which is decoded from state.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Access geometry: size = 1/2/4 bytes; off = addr[1:0]; crossing when off + size > 4.
- FSM states and transitions:
  - IDLE: on req_valid, latch we, funct3, addr and wdata.
    - Illegal funct3, or crossing with ALLOW_MISALIGNED = 0: go to RESP with err = 1; no memory access.
    - Otherwise: go to ACC0.
  - ACC0: mem_req = 1; mem_addr = {addr[AW-1:2], 2'b00}.
    - On mem_ack: go to ACC1 if crossing, else RESP.
  - ACC1: mem_req = 1; mem_addr = first word + 4, wrapping modulo 2^ADDR_WIDTH.
    - On mem_ack: go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- mem_req rises the cycle after entering ACC0/ACC1 and stays high until mem_ack is sampled.
- On an ACC0→ACC1 transition, mem_req stays high continuously; only mem_addr, mem_wstrb and mem_wdata change.
- mem_ack is ignored when mem_req = 0.
- Stores:
  - 8-bit mask: 0x1 / 0x3 / 0xF for byte / half / word.
  - Shifted mask: S = mask << off. ACC0 mem_wstrb = S[3:0]; ACC1 mem_wstrb = S[7:4].
  - Data: D = {32'b0, wdata} << (8*off). ACC0 mem_wdata = D[31:0]; ACC1 mem_wdata = D[63:32].
- Loads:
  - ACC0 mem_rdata is captured into the low word; ACC1 mem_rdata into the high word.
  - Result = ({hi, lo} >> (8*off)) truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - mem_wstrb = 0 for loads.
- Latency:
  - Aligned with zero-wait ack: request accepted at edge 0, mem_req high in cycle 1, resp_valid high in cycle 2. Each wait cycle adds one.
  - Split access: one additional transaction.
  - Error: resp_valid in cycle 1.
- Requests arriving while req_ready = 0 are not accepted; the core must hold req_valid.

Test Plan:
- Aligned LW 0x100, mem_rdata 0xDEADBEEF, zero-wait ack → mem_addr 0x100, resp_valid in cycle 2, resp_rdata 0xDEADBEEF, resp_err 0.
- LB 0x103, mem_rdata 0x80000000 → resp_rdata 0xFFFFFF80. Same access as LBU → 0x00000080.
- SH 0x102, wdata 0x0000ABCD → single transaction, mem_wstrb 0xC, mem_wdata 0xABCD0000.
- LW 0x0FE (ALLOW_MISALIGNED = 1), ack with 0x33221100 then 0x77665544 → transactions at 0x0FC then 0x100, resp_rdata 0x55443322.
- SW 0x0FF, wdata 0xAABBCCDD → strobes 0x8 / data 0xDD000000 at 0x0FC, then strobes 0x7 / data 0x00AABBCC at 0x100.
- Address 0xFFFFFFFE split → second access at 0x00000000.
- Error cases: funct3 011 → resp_err 1 in cycle 1, no mem_req. ALLOW_MISALIGNED = 0 with LH 0x003 → resp_err 1, no mem_req.
- rst asserted while mem_req is high with ack withheld → mem_req 0 immediately, no resp_valid, req_ready 1. A following aligned LW completes normally.

Source files
------------

// File: rtl/lsu_split.sv
// Load/store unit between the execute stage and a handshaked word memory.
// Byte/half/word accesses with sign/zero extension; word-crossing accesses split in two.
module lsu_split #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned DATA_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t          r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_lo;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [3:0]      r_mem_wstrb;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic [DW-1:0]   r_resp_rdata;

  state_t          w_nxt_state;
  logic            w_nxt_mem_req;
  logic            w_nxt_mem_we;
  logic [AW-1:0]   w_nxt_mem_addr;
  logic [3:0]      w_nxt_mem_wstrb;
  logic [DW-1:0]   w_nxt_mem_wdata;
  logic            w_nxt_resp_valid;
  logic            w_nxt_resp_err;
  logic [DW-1:0]   w_nxt_resp_rdata;

  logic            w_idle;
  logic            w_we;
  logic [2:0]      w_f3;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [1:0]      w_off;
  logic [AW-1:0]   w_base;
  logic [2:0]      w_size;
  logic [3:0]      w_mask4;
  logic [7:0]      w_smask;
  logic [2*DW-1:0] w_dsh;
  logic            w_cross;
  logic            w_illegal;
  logic [DW-1:0]   w_lo;
  logic [DW-1:0]   w_ld_sh;
  logic [DW-1:0]   w_load;

  // In IDLE the incoming request drives the geometry so ACC0 outputs can be registered at acceptance.
  assign w_idle  = (r_state == S_IDLE);
  assign w_we    = w_idle ? req_we     : r_we;
  assign w_f3    = w_idle ? req_funct3 : r_funct3;
  assign w_addr  = w_idle ? req_addr   : r_addr;
  assign w_wdata = w_idle ? req_wdata  : r_wdata;
  assign w_off   = w_addr[1:0];
  assign w_base  = {w_addr[AW-1:2], 2'b00};

  always_comb begin
    w_size  = 3'd4;
    w_mask4 = 4'hF;
    case (w_f3[1:0])
      2'b00:   begin w_size = 3'd1; w_mask4 = 4'h1; end
      2'b01:   begin w_size = 3'd2; w_mask4 = 4'h3; end
      default: begin w_size = 3'd4; w_mask4 = 4'hF; end
    endcase
  end

  assign w_cross   = (({1'b0, w_off} + w_size) > 3'd4);
  assign w_illegal = w_we ? (w_f3[2] || (w_f3[1:0] == 2'b11))
                          : ((w_f3 == 3'b011) || (w_f3[2:1] == 2'b11));
  assign w_smask   = {4'b0000, w_mask4} << w_off;
  assign w_dsh     = {{DW{1'b0}}, w_wdata} << {w_off, 3'b000};

  // Load assembly: low word from ACC0 (live or captured), high word is always the live ACC1 data.
  assign w_lo    = (r_state == S_ACC0) ? mem_rdata : r_lo;
  assign w_ld_sh = DW'({mem_rdata, w_lo} >> {w_off, 3'b000});

  always_comb begin
    case (w_f3)
      3'b000:  w_load = {{(DW-8){w_ld_sh[7]}},   w_ld_sh[7:0]};
      3'b001:  w_load = {{(DW-16){w_ld_sh[15]}}, w_ld_sh[15:0]};
      3'b100:  w_load = {{(DW-8){1'b0}},         w_ld_sh[7:0]};
      3'b101:  w_load = {{(DW-16){1'b0}},        w_ld_sh[15:0]};
      default: w_load = w_ld_sh;
    endcase
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_mem_req    = 1'b0;
    w_nxt_mem_we     = 1'b0;
    w_nxt_mem_addr   = '0;
    w_nxt_mem_wstrb  = 4'h0;
    w_nxt_mem_wdata  = '0;
    w_nxt_resp_valid = 1'b0;
    w_nxt_resp_err   = 1'b0;
    w_nxt_resp_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_illegal || (w_cross && !ALLOW_MISALIGNED)) begin
            w_nxt_state      = S_RESP;
            w_nxt_resp_valid = 1'b1;
            w_nxt_resp_err   = 1'b1;
          end else begin
            w_nxt_state     = S_ACC0;
            w_nxt_mem_req   = 1'b1;
            w_nxt_mem_we    = w_we;
            w_nxt_mem_addr  = w_base;
            w_nxt_mem_wstrb = w_we ? w_smask[3:0] : 4'h0;
            w_nxt_mem_wdata = w_we ? w_dsh[DW-1:0] : '0;
          end
        end
      end
      S_ACC0, S_ACC1: begin
        w_nxt_mem_req   = r_mem_req;
        w_nxt_mem_we    = r_mem_we;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wstrb = r_mem_wstrb;
        w_nxt_mem_wdata = r_mem_wdata;
        if (mem_ack) begin
          if ((r_state == S_ACC0) && w_cross) begin
            w_nxt_state     = S_ACC1;
            w_nxt_mem_addr  = w_base + AW'(4);
            w_nxt_mem_wstrb = w_we ? w_smask[7:4] : 4'h0;
            w_nxt_mem_wdata = w_we ? w_dsh[2*DW-1:DW] : '0;
          end else begin
            w_nxt_state      = S_RESP;
            w_nxt_mem_req    = 1'b0;
            w_nxt_mem_we     = 1'b0;
            w_nxt_mem_addr   = '0;
            w_nxt_mem_wstrb  = 4'h0;
            w_nxt_mem_wdata  = '0;
            w_nxt_resp_valid = 1'b1;
            w_nxt_resp_rdata = w_we ? '0 : w_load;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'h0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_mem_req    <= w_nxt_mem_req;
      r_mem_we     <= w_nxt_mem_we;
      r_mem_addr   <= w_nxt_mem_addr;
      r_mem_wstrb  <= w_nxt_mem_wstrb;
      r_mem_wdata  <= w_nxt_mem_wdata;
      r_resp_valid <= w_nxt_resp_valid;
      r_resp_err   <= w_nxt_resp_err;
      r_resp_rdata <= w_nxt_resp_rdata;
    end
  end

  // Request fields are captured only on acceptance; the low read word on the first ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
    end else begin
      if (w_idle && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if ((r_state == S_ACC0) && mem_ack) begin
        r_lo <= mem_rdata;
      end
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: byte-level memory model, directed cases, then randomized accesses.
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        n_req_valid, n_req_ready, n_req_we;
  logic [2:0]  n_req_funct3;
  logic [31:0] n_req_addr, n_req_wdata;
  logic        n_resp_valid, n_resp_err;
  logic [31:0] n_resp_rdata;
  logic        n_mem_req, n_mem_we, n_mem_ack;
  logic [31:0] n_mem_addr, n_mem_wdata, n_mem_rdata;
  logic [3:0]  n_mem_wstrb;

  int vectors = 0;
  int errors  = 0;
  bit [7:0] mem [bit [31:0]];

  always #5 clk = ~clk;

  lsu_split #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  lsu_split #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0), .DATA_WIDTH(32)) dut_na (
    .clk(clk), .rst(rst), .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
    .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wstrb(n_mem_wstrb),
    .mem_wdata(n_mem_wdata), .mem_ack(n_mem_ack), .mem_rdata(n_mem_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Issues one access at a negedge in IDLE, plays memory with random waits, checks everything.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int maxw,
                           output logic [31:0] obs_rdata, output logic obs_err);
    int size, off, n, idx, c, w, lat, j;
    logic illegal, done;
    logic [31:0] eaddr [2];
    logic [3:0]  estrb [2];
    logic [31:0] ewd   [2];
    logic [31:0] erd;

    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
    off     = int'(addr[1:0]);
    n       = illegal ? 0 : ((off + size > 4) ? 2 : 1);
    for (int i = 0; i < 2; i++) begin
      eaddr[i] = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
      estrb[i] = 4'h0;
      ewd[i]   = 32'h0;
      for (int k = 0; k < 4; k++) begin
        j = 4 * i + k - off;
        if (we && j >= 0 && j < size) estrb[i][k] = 1'b1;
        if (j >= 0 && j < 4) ewd[i][8*k +: 8] = wdata[8*j +: 8];
      end
    end
    erd = 32'h0;
    if (!we && !illegal) begin
      for (int i = 0; i < size; i++) erd |= 32'(rd_byte(addr + 32'(i))) << (8 * i);
      if (f3 == 3'd0 && erd[7])  erd |= 32'hFFFF_FF00;
      if (f3 == 3'd1 && erd[15]) erd |= 32'hFFFF_0000;
    end

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    idx = 0; c = 1; done = 1'b0;
    obs_rdata = 32'h0; obs_err = 1'b0;
    w   = $urandom_range(0, maxw);
    lat = 1 + n + ((n > 0) ? w : 0);
    while (!done && c <= 24) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (idx < n) begin
        chk("mem_req_held", 32'(mem_req), 32'd1);
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        chk("busy_not_ready", 32'(req_ready), 32'd0);
        chk("mem_addr", mem_addr, eaddr[idx]);
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(estrb[idx]));
        if (we) chk("mem_wdata", mem_wdata, ewd[idx]);
        req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (w == 0) begin
          mem_ack = 1'b1;
          if (we) begin
            for (int k = 0; k < 4; k++)
              if (mem_wstrb[k]) mem[mem_addr + 32'(k)] = mem_wdata[8*k +: 8];
          end else begin
            mem_rdata = rd_word(eaddr[idx]);
          end
          idx++;
          w = $urandom_range(0, maxw);
          if (idx < n) lat += w;
        end else begin
          w--;
        end
      end else begin
        req_valid = 1'b0;
        mem_ack   = 1'($urandom);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(illegal));
        chk("resp_rdata", resp_rdata, erd);
        chk("mem_req_idle", 32'(mem_req), 32'd0);
        chk("latency", 32'(c), 32'(lat));
        obs_rdata = resp_rdata; obs_err = resp_err;
        done = 1'b1;
      end
      c++;
    end
    vectors++;
    assert (done) else begin
      errors++;
      $error("FAIL timeout: observed %0d cycles expected response by %0d", c, lat);
    end
    @(negedge clk);
    req_valid = 1'b0; mem_ack = 1'b0;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a;
    logic [2:0]  ltab [5];
    ltab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_req_valid = 1'b0; n_req_we = 1'b0; n_req_funct3 = 3'd0; n_req_addr = 32'h0;
    n_req_wdata = 32'h0; n_mem_ack = 1'b0; n_mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    set_word(32'h100, 32'hDEAD_BEEF);
    do_access(1'b0, 3'd2, 32'h100, 32'h0, 0, r, e);
    chk("tp_lw", r, 32'hDEAD_BEEF);
    chk("tp_lw_err", 32'(e), 32'd0);

    set_word(32'h100, 32'h8000_0000);
    do_access(1'b0, 3'd0, 32'h103, 32'h0, 0, r, e);
    chk("tp_lb", r, 32'hFFFF_FF80);
    do_access(1'b0, 3'd4, 32'h103, 32'h0, 1, r, e);
    chk("tp_lbu", r, 32'h0000_0080);

    do_access(1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 0, r, e);
    do_access(1'b0, 3'd5, 32'h102, 32'h0, 0, r, e);
    chk("tp_sh_readback", r, 32'h0000_ABCD);

    set_word(32'h0FC, 32'h3322_1100);
    set_word(32'h100, 32'h7766_5544);
    do_access(1'b0, 3'd2, 32'h0FE, 32'h0, 0, r, e);
    chk("tp_lw_split", r, 32'h5544_3322);

    do_access(1'b1, 3'd2, 32'h0FF, 32'hAABB_CCDD, 1, r, e);
    do_access(1'b0, 3'd2, 32'h0FC, 32'h0, 0, r, e);
    chk("tp_sw_split_lo", r, 32'hDD22_1100);
    do_access(1'b0, 3'd2, 32'h100, 32'h0, 0, r, e);
    chk("tp_sw_split_hi", r, 32'h77AA_BBCC);

    set_word(32'hFFFF_FFFC, 32'h4433_2211);
    set_word(32'h0000_0000, 32'h8877_6655);
    do_access(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 0, r, e);
    chk("tp_wrap", r, 32'h6655_4433);

    do_access(1'b0, 3'd3, 32'h100, 32'h0, 0, r, e);
    chk("tp_illegal_ld", 32'(e), 32'd1);
    do_access(1'b1, 3'd4, 32'h100, 32'h1234, 0, r, e);
    chk("tp_illegal_st", 32'(e), 32'd1);

    // Unit built without misaligned support must reject word-crossing accesses.
    for (int t = 0; t < 2; t++) begin
      n_req_valid = 1'b1; n_req_we = 1'b0;
      n_req_funct3 = (t == 0) ? 3'd1 : 3'd2;
      n_req_addr   = (t == 0) ? 32'h3 : 32'h2;
      @(posedge clk);
      @(negedge clk);
      n_req_valid = 1'b0;
      chk("na_resp_valid", 32'(n_resp_valid), 32'd1);
      chk("na_resp_err", 32'(n_resp_err), 32'd1);
      chk("na_resp_rdata", n_resp_rdata, 32'h0);
      chk("na_no_mem_req", 32'(n_mem_req), 32'd0);
      @(negedge clk);
      chk("na_resp_done", 32'(n_resp_valid), 32'd0);
      chk("na_no_mem_req2", 32'(n_mem_req), 32'd0);
    end

    // Reset while a transaction waits on ack.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_ack = 1'b0;
    chk("rst_mid_pre", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_resp2", 32'(resp_valid), 32'd0);
    chk("rst_mid_mem_req2", 32'(mem_req), 32'd0);
    set_word(32'h300, 32'h1234_5678);
    do_access(1'b0, 3'd2, 32'h300, 32'h0, 0, r, e);
    chk("rst_after_lw", r, 32'h1234_5678);

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 19) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ltab[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h200 + 32'($urandom_range(0, 31));
      do_access(we, f3, a, $urandom, 2, r, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
